// File: rtl/id_exe_pipe_pkg.sv
// rtl/id_exe_pipe_pkg.sv - shared constants and widths for the ID->EXE pipeline register
package id_exe_pipe_pkg;

    localparam int INST_DATA_W = 32;
    localparam int INST_ADDR_W = 32;
    localparam int REG_DATA_W  = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int PERF_CNT_W  = 16;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP      = 32'h0000_0013;
    localparam logic [31:0] ZERO          = 32'h0000_0000;
    localparam logic [4:0]  ZERO_REG      = 5'd0;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic [6:0]  INST_TYPE_L   = 7'b000_0011;

    function automatic logic is_load_opcode(input logic [6:0] opcode);
        return opcode == INST_TYPE_L;
    endfunction

endpackage

// File: rtl/id_exe_pipe_slot.sv
// rtl/id_exe_pipe_slot.sv - one pipeline slot: payload register plus valid bit
// Clear only drops the valid bit so the payload (and thus the PC) keeps its last value.
module id_exe_pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         reset_n_in,
    input  logic         load_in,
    input  logic         clear_in,
    input  logic [W-1:0] data_in,
    output logic         valid_out,
    output logic [W-1:0] data_out
);

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (clear_in) begin
            valid_out <= 1'b0;
        end else if (load_in) begin
            valid_out <= 1'b1;
            data_out  <= data_in;
        end
    end

endmodule

// File: rtl/id_exe_pipe.sv
// rtl/id_exe_pipe.sv - ID->EXE stage register with valid/ready handshake and one-entry skid buffer
// Optional performance counters are built when ID_EXE_PIPE_PERF_EN is defined.
module id_exe_pipe
    import id_exe_pipe_pkg::*;
#(
    parameter int DATA_W  = INST_DATA_W,
    parameter int ADDR_W  = INST_ADDR_W,
    parameter int RDATA_W = REG_DATA_W,
    parameter int RADDR_W = REG_ADDR_W,
    parameter int PERF_W  = PERF_CNT_W
) (
    input  logic               clk_in,
    input  logic               reset_n_in,
    input  logic               in_valid_in,
    output logic               in_ready_out,
    input  logic [DATA_W-1:0]  inst_in,
    input  logic [ADDR_W-1:0]  inst_address_in,
    input  logic [RDATA_W-1:0] op1_in,
    input  logic [RDATA_W-1:0] op2_in,
    input  logic [RADDR_W-1:0] reg_waddr_in,
    input  logic               reg_we_in,
    input  logic               flush_in,
    output logic               out_valid_out,
    input  logic               out_ready_in,
    output logic [DATA_W-1:0]  inst_out,
    output logic [ADDR_W-1:0]  inst_address_out,
    output logic [RDATA_W-1:0] op1_out,
    output logic [RDATA_W-1:0] op2_out,
    output logic [RADDR_W-1:0] reg_waddr_out,
    output logic               reg_we_out,
    output logic               hz_load_out,
    output logic [RADDR_W-1:0] hz_rd_out,
    output logic [PERF_W-1:0]  stall_cnt_out,
    output logic [PERF_W-1:0]  flush_cnt_out
);

    localparam int PAY_W = DATA_W + ADDR_W + 2 * RDATA_W + RADDR_W + 1;

    logic [PAY_W-1:0] pay_in, main_d, main_q, skid_q;
    logic main_valid, skid_valid;
    logic accept, drain;
    logic main_load, main_clear, skid_load, skid_clear;

    logic [DATA_W-1:0]  m_inst;
    logic [ADDR_W-1:0]  m_addr;
    logic [RDATA_W-1:0] m_op1, m_op2;
    logic [RADDR_W-1:0] m_waddr;
    logic               m_we;

    assign pay_in = {inst_in, inst_address_in, op1_in, op2_in, reg_waddr_in, reg_we_in};
    assign {m_inst, m_addr, m_op1, m_op2, m_waddr, m_we} = main_q;

    // Ready comes straight from the skid flop, so out_ready_in never reaches in_ready_out.
    assign in_ready_out = !skid_valid;
    assign accept       = in_valid_in && in_ready_out;
    assign drain        = main_valid && out_ready_in;

    assign main_load  = !flush_in &&
                        ((skid_valid && drain) ||
                         (!skid_valid && accept && (!main_valid || drain)));
    assign main_d     = skid_valid ? skid_q : pay_in;
    assign main_clear = flush_in || (drain && !main_load);

    assign skid_load  = !flush_in && accept && main_valid && !drain;
    assign skid_clear = flush_in || (skid_valid && drain);

    id_exe_pipe_slot #(.W(PAY_W)) u_main (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .load_in    (main_load),
        .clear_in   (main_clear),
        .data_in    (main_d),
        .valid_out  (main_valid),
        .data_out   (main_q)
    );

    id_exe_pipe_slot #(.W(PAY_W)) u_skid (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .load_in    (skid_load),
        .clear_in   (skid_clear),
        .data_in    (pay_in),
        .valid_out  (skid_valid),
        .data_out   (skid_q)
    );

    // An invalid main slot presents a harmless bubble; the PC is left as-is.
    assign out_valid_out    = main_valid;
    assign inst_out         = main_valid ? m_inst  : DATA_W'(INST_NOP);
    assign inst_address_out = m_addr;
    assign op1_out          = main_valid ? m_op1   : RDATA_W'(ZERO);
    assign op2_out          = main_valid ? m_op2   : RDATA_W'(ZERO);
    assign reg_waddr_out    = main_valid ? m_waddr : RADDR_W'(ZERO_REG);
    assign reg_we_out       = main_valid ? m_we    : WRITE_DISABLE;

    assign hz_load_out = main_valid && is_load_opcode(m_inst[6:0]);
    assign hz_rd_out   = main_valid ? RADDR_W'(m_inst[11:7]) : RADDR_W'(ZERO_REG);

`ifdef ID_EXE_PIPE_PERF_EN
    logic [1:0]        kill_num;
    logic [PERF_W:0]   flush_sum;
    logic [PERF_W-1:0] stall_cnt, flush_cnt;

    // A main entry drained in the flush cycle reaches EXE and is not counted as lost.
    assign kill_num  = {1'b0, main_valid && !drain} + {1'b0, skid_valid};
    assign flush_sum = {1'b0, flush_cnt} + {{(PERF_W - 1){1'b0}}, kill_num};

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (main_valid && !out_ready_in && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_in)
                flush_cnt <= flush_sum[PERF_W] ? '1 : flush_sum[PERF_W-1:0];
        end
    end

    assign stall_cnt_out = stall_cnt;
    assign flush_cnt_out = flush_cnt;
`else
    assign stall_cnt_out = '0;
    assign flush_cnt_out = '0;
`endif

endmodule

// File: tb/tb_id_exe_pipe.sv
// tb/tb_id_exe_pipe.sv - directed self-checking bench for id_exe_pipe
module tb_id_exe_pipe;

`ifdef ID_EXE_PIPE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] inst_i, addr_i, op1_i, op2_i;
    logic [4:0]  waddr_i;
    logic        we_i;
    logic [31:0] inst_o, addr_o, op1_o, op2_o;
    logic [4:0]  waddr_o, hz_rd;
    logic        we_o, hz_load;
    logic [3:0]  stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_exe_pipe #(.PERF_W(4)) dut (
        .clk_in           (clk),
        .reset_n_in       (rst_n),
        .in_valid_in      (in_valid),
        .in_ready_out     (in_ready),
        .inst_in          (inst_i),
        .inst_address_in  (addr_i),
        .op1_in           (op1_i),
        .op2_in           (op2_i),
        .reg_waddr_in     (waddr_i),
        .reg_we_in        (we_i),
        .flush_in         (flush),
        .out_valid_out    (out_valid),
        .out_ready_in     (out_ready),
        .inst_out         (inst_o),
        .inst_address_out (addr_o),
        .op1_out          (op1_o),
        .op2_out          (op2_o),
        .reg_waddr_out    (waddr_o),
        .reg_we_out       (we_o),
        .hz_load_out      (hz_load),
        .hz_rd_out        (hz_rd),
        .stall_cnt_out    (stall_cnt),
        .flush_cnt_out    (flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_inst(input int k);
        return {20'(k + 32'hA000), 5'(k + 1), 7'b011_0011};
    endfunction

    task automatic drive(input int k);
        in_valid = 1'b1;
        inst_i   = mk_inst(k);
        addr_i   = 32'h100 + 32'(4 * k);
        op1_i    = 32'(3 * k + 1);
        op2_i    = ~32'(k);
        waddr_i  = 5'(k + 1);
        we_i     = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_item(input string tag, input int k);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_inst"}, inst_o, mk_inst(k));
        chk({tag, "_addr"}, addr_o, 32'h100 + 32'(4 * k));
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_inst"}, inst_o, 32'h0000_0013);
        chk({tag, "_op1"}, op1_o, 32'd0);
        chk({tag, "_we"}, 32'(we_o), 32'd0);
        chk({tag, "_waddr"}, 32'(waddr_o), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        inst_i = '0; addr_i = '0; op1_i = '0; op2_i = '0; waddr_i = '0; we_i = 1'b0;
        #1;
        chk_bubble("rst");
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_addr", addr_o, 32'd0);
        chk("rst_hz_load", 32'(hz_load), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // back-to-back stream, one result per cycle after one cycle of latency
        for (int k = 0; k < 8; k++) begin
            drive(k);
            step();
            chk_item("b2b", k);
            chk("b2b_op1", op1_o, 32'(3 * k + 1));
            chk("b2b_hz_rd", 32'(hz_rd), 32'(k + 1));
            chk("b2b_hz_load", 32'(hz_load), 32'd0);
        end
        in_valid = 1'b0;
        step();
        chk_bubble("b2b_end");
        chk("b2b_end_addr_kept", addr_o, 32'h100 + 32'd28);
        chk("b2b_stall", 32'(stall_cnt), 32'd0);

        // backpressure: A to main, B to skid, C held off
        out_ready = 1'b0;
        drive(20); step();
        chk_item("bp_a", 20);
        drive(21); step();
        chk("bp_ready_two", 32'(in_ready), 32'd0);
        drive(22); step();
        step();
        chk_item("bp_hold", 20);
        chk("bp_ready_hold", 32'(in_ready), 32'd0);
        chk("bp_stall3", 32'(stall_cnt), PERF ? 32'd3 : 32'd0);
        out_ready = 1'b1;
        step();
        chk_item("bp_b", 21);
        chk("bp_ready_one", 32'(in_ready), 32'd1);
        step();
        chk_item("bp_c", 22);
        in_valid = 1'b0;
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_stall_keep", 32'(stall_cnt), PERF ? 32'd3 : 32'd0);

        // flush in TWO kills both slots and ignores the offered input
        out_ready = 1'b0;
        drive(30); step();
        drive(31); step();
        drive(32); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        chk_bubble("fl_two");
        chk("fl_two_ready", 32'(in_ready), 32'd1);
        chk("fl_two_cnt", 32'(flush_cnt), PERF ? 32'd2 : 32'd0);
        chk("fl_two_stall", 32'(stall_cnt), PERF ? 32'd5 : 32'd0);
        step();
        chk("fl_no_capture", 32'(out_valid), 32'd0);

        // flush while draining: drained entry is consumed, new input discarded
        out_ready = 1'b1;
        drive(40); step();
        chk_item("fl_drain_pre", 40);
        drive(41); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_drain_valid", 32'(out_valid), 32'd0);
        chk("fl_drain_cnt", 32'(flush_cnt), PERF ? 32'd2 : 32'd0);

        // load-use hazard export
        out_ready = 1'b0;
        drive(50);
        inst_i = {12'h004, 5'd1, 3'b010, 5'd7, 7'b000_0011};
        step();
        in_valid = 1'b0;
        chk("hz_load", 32'(hz_load), 32'd1);
        chk("hz_rd", 32'(hz_rd), 32'd7);
        out_ready = 1'b1;
        step();
        chk("hz_load_gone", 32'(hz_load), 32'd0);
        chk("hz_rd_gone", 32'(hz_rd), 32'd0);

        // stall counter saturation, then async reset from TWO
        out_ready = 1'b0;
        drive(60); step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("sat_stall", 32'(stall_cnt), PERF ? 32'd15 : 32'd0);
        drive(61); step();
        in_valid = 1'b0;
        chk("two_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_bubble("arst");
        chk("arst_ready", 32'(in_ready), 32'd1);
        chk("arst_addr", addr_o, 32'd0);
        chk("arst_stall", 32'(stall_cnt), 32'd0);
        chk("arst_flush", 32'(flush_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_stay_empty", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
